btn_irq_ctrl: RTL and testbench
===============================

Name: btn_irq_ctrl

Overview:
- Sits upstream of the PacoBlaze3 core in the Papilio Duo top level.
- Takes the raw joystick/button pins (DIR_RIGHT, DIR_LEFT, ...), synchronises and debounces them, and latches rising-edge events.
- Drives the core's interrupt/interrupt_ack handshake from those events.
- Exposes event status, live levels and an interrupt mask on the core's I/O port bus.

Parameters:
- N_BTN, 2, number of button inputs; legal range 1..4.
- DEBOUNCE_CYCLES, 320000, cycles a synced input must stay stable before it is accepted (10 ms at 32 MHz); minimum 2.
- CNT_W, 19, debounce counter width; requires 2^CNT_W > DEBOUNCE_CYCLES.
- PORT_STATUS, 8'h02, read port: status byte. Write port: write-1-to-clear pending bits.
- PORT_MASK, 8'h03, read/write port: interrupt enable mask.

Ports:
- clk  in  1  system clock (32 MHz).
- rst_n  in  1  synchronous reset, active low.
- btn_raw  in  N_BTN  asynchronous raw button pins, active high.
- port_id  in  8  core port address.
- read_strobe  in  1  core read strobe.
- write_strobe  in  1  core write strobe.
- out_port  in  8  core write data.
- in_data  out  8  read data; valid when in_sel=1, otherwise 8'h00.
- in_sel  out  1  combinational; 1 when port_id equals PORT_STATUS or PORT_MASK. Used by the top-level read mux.
- interrupt  out  1  interrupt request to the core, registered.
- interrupt_ack  in  1  acknowledge pulse from the core.
- btn_level  out  N_BTN  debounced stable levels, registered.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all state: sync FFs, counters, stable levels, pending, state.
  - Outputs after reset: btn_level=0, interrupt=0, pending=0, mask=all ones (low N_BTN bits).
  - Reset mid-debounce or mid-interrupt aborts immediately; no event survives reset.
- Synchroniser: 2-FF per input.
- Debounce, per bit:
  - If sync != stable, counter increments; otherwise counter clears to 0.
  - When counter == DEBOUNCE_CYCLES-1 and sync != stable: stable <= sync and counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable.
  - Latency from a raw edge to btn_level change = 2 + DEBOUNCE_CYCLES cycles.
- Event latch:
  - A rising edge of stable[i] sets pending[i] on the same edge that stable rises.
  - Falling edges are ignored.
  - pending clears only by a write to PORT_STATUS (write_strobe with port_id==PORT_STATUS): pending <= pending & ~out_port[N_BTN-1:0].
  - If set and clear hit the same cycle, set wins.
- Mask: a write to PORT_MASK loads mask <= out_port[N_BTN-1:0].
- Read data (combinational):
  - PORT_STATUS returns {pending zero-extended to 4 bits, btn_level zero-extended to 4 bits}; bits 7:4 = pending, 3:0 = level.
  - PORT_MASK returns {4'b0, mask zero-extended}.
  - Reads have no side effects; read_strobe is accepted but unused.
- IRQ FSM, states IDLE, REQ, SERVICE:
  - IDLE: if |(pending & mask), go to REQ next edge; interrupt=1 from that edge.
  - REQ: interrupt held at 1 until interrupt_ack=1. On ack, go to SERVICE with interrupt=0 on the same edge.
  - SERVICE: interrupt=0. When (pending & mask)==0, go to IDLE. New events arriving in SERVICE stay pending; if any remain unmasked, SERVICE persists and a new request follows only after software clears all unmasked pending bits.
  - Masking all bits while in REQ drops to IDLE with interrupt=0; no ack is required.
  - interrupt_ack outside REQ is ignored.
- Pending-to-interrupt latency: 1 cycle.

Decomposition:
- Shared package/include (btn_irq_inc.v): PORT_STATUS/PORT_MASK default addresses, FSM state encodings (IDLE=2'd0, REQ=2'd1, SERVICE=2'd2), default DEBOUNCE_CYCLES.
- Sub-module debounce_filter: 1-bit synchroniser plus counter, parameters DEBOUNCE_CYCLES/CNT_W, outputs stable and rise. Instantiated N_BTN times via generate.
- Event latch, mask, port decode and FSM stay in btn_irq_ctrl.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, N_BTN=2.
- Bounce rejection: btn_raw[0] pulses high for 3 cycles, 5 times -> btn_level=2'b00, interrupt stays 0, status read = 8'h00.
- Clean press: btn_raw[0] rises and holds -> btn_level[0]=1 exactly 6 cycles later; pending=2'b01 on the same edge; interrupt=1 one cycle later; status read = 8'h11.
- Handshake: with interrupt=1, pulse interrupt_ack -> interrupt=0 next edge. Write 8'h01 to 8'h02 -> status = 8'h01, FSM IDLE, interrupt stays 0.
- Mask: write 8'h00 to 8'h03, then press btn[1] -> pending=2'b10, interrupt=0. Write 8'h02 to 8'h03 -> interrupt=1 one cycle later.
- Set/clear collision: clear write to 8'h02 with data 8'h01 on the same cycle btn[0] stable rises -> pending[0] remains 1.
- Reset mid-request: drive rst_n=0 for 1 cycle while interrupt=1 -> interrupt=0, status=8'h00, mask read=8'h03.

Source files
------------

// File: rtl/btn_irq_ctrl_pkg.sv
// Shared definitions for the button interrupt controller: default port
// addresses, default debounce settings and the IRQ state encoding.
package btn_irq_ctrl_pkg;

    localparam logic [7:0] PORT_STATUS_DEFAULT     = 8'h02;
    localparam logic [7:0] PORT_MASK_DEFAULT       = 8'h03;
    localparam int         DEBOUNCE_CYCLES_DEFAULT = 320000;
    localparam int         CNT_W_DEFAULT           = 19;

    // Interrupt handshake states, encoded as seen on dbg_state.
    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_REQ     = 2'd1,
        IRQ_SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/btn_irq_ctrl_debounce_filter.sv
// One-bit button conditioner: 2-FF synchroniser followed by a stability
// counter. "stable" only follows the synced input after it has disagreed
// with stable for DEBOUNCE_CYCLES consecutive cycles. "rise" is high in the
// cycle whose clock edge will take stable from 0 to 1, so a downstream
// register can capture the event on the same edge that stable rises.
module debounce_filter
    import btn_irq_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign accept = (sync_q2 != stable) && (cnt == CNT_LAST);
    assign rise   = accept & sync_q2;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync_q2 != stable) begin
            if (accept) begin
                stable <= sync_q2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/btn_irq_ctrl.sv
// Button interrupt controller for the PacoBlaze3 core: debounces the raw
// button pins, latches rising-edge events as pending bits, raises an
// interrupt for unmasked pending events and exposes status/mask registers
// on the core's I/O port bus.
//
// Handshake: interrupt is a level request held until the core pulses
// interrupt_ack (only honoured while requesting). After the ack no new
// request is raised until software has cleared every unmasked pending bit.
module btn_irq_ctrl
    import btn_irq_ctrl_pkg::*;
#(
    parameter int         N_BTN           = 2,
    parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int         CNT_W           = CNT_W_DEFAULT,
    parameter logic [7:0] PORT_STATUS     = PORT_STATUS_DEFAULT,
    parameter logic [7:0] PORT_MASK       = PORT_MASK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [7:0]       port_id,
    input  logic             read_strobe,
    input  logic             write_strobe,
    input  logic [7:0]       out_port,
    output logic [7:0]       in_data,
    output logic             in_sel,
    output logic             interrupt,
    input  logic             interrupt_ack,
    output logic [N_BTN-1:0] btn_level,
    output logic [1:0]       dbg_state
);

    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] mask;
    logic             status_wr;
    logic             mask_wr;
    logic             irq_active;
    irq_state_t       state;
    irq_state_t       state_next;
    logic             unused_inputs;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_filter #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_raw(btn_raw[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    assign btn_level  = stable;
    assign status_wr  = write_strobe && (port_id == PORT_STATUS);
    assign mask_wr    = write_strobe && (port_id == PORT_MASK);
    assign irq_active = |(pending & mask);
    assign in_sel     = (port_id == PORT_STATUS) || (port_id == PORT_MASK);
    assign dbg_state  = state;

    // Reads are side-effect free; upper write-data bits have no register.
    assign unused_inputs = ^{read_strobe, out_port[7:N_BTN]};

    // Event latch and mask register; a new event wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            mask    <= '1;
        end else begin
            if (status_wr) begin
                pending <= (pending & ~out_port[N_BTN-1:0]) | rise;
            end else begin
                pending <= pending | rise;
            end
            if (mask_wr) begin
                mask <= out_port[N_BTN-1:0];
            end
        end
    end

    // IRQ state register; interrupt is registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IRQ_IDLE;
            interrupt <= 1'b0;
        end else begin
            state     <= state_next;
            interrupt <= (state_next == IRQ_REQ);
        end
    end

    // IRQ next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IRQ_IDLE: begin
                if (irq_active) state_next = IRQ_REQ;
            end
            IRQ_REQ: begin
                if (!irq_active)        state_next = IRQ_IDLE;
                else if (interrupt_ack) state_next = IRQ_SERVICE;
            end
            IRQ_SERVICE: begin
                if (!irq_active) state_next = IRQ_IDLE;
            end
            default: state_next = IRQ_IDLE;
        endcase
    end

    // Read mux: status = {pending, level}, mask = {0, mask}, nibble aligned.
    always_comb begin
        logic [3:0] pend4;
        logic [3:0] lvl4;
        logic [3:0] mask4;
        pend4               = '0;
        lvl4                = '0;
        mask4               = '0;
        pend4[N_BTN-1:0]    = pending;
        lvl4[N_BTN-1:0]     = stable;
        mask4[N_BTN-1:0]    = mask;
        in_data             = 8'h00;
        if (port_id == PORT_STATUS) begin
            in_data = {pend4, lvl4};
        end else if (port_id == PORT_MASK) begin
            in_data = {4'h0, mask4};
        end
    end

endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Bench for btn_irq_ctrl with a 4-cycle debounce and two buttons. A
// behavioural model predicts level/interrupt every cycle and read data for
// every issued read; a monitor pops the expectations and compares.
module tb_btn_irq_ctrl;

  localparam int N_BTN = 2;
  localparam int DC    = 4;
  localparam int CNT_W = 3;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_BTN-1:0] btn_raw;
  logic [7:0]       port_id;
  logic             read_strobe;
  logic             write_strobe;
  logic [7:0]       out_port;
  logic [7:0]       in_data;
  logic             in_sel;
  logic             interrupt;
  logic             interrupt_ack;
  logic [N_BTN-1:0] btn_level;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  btn_irq_ctrl #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (CNT_W),
    .PORT_STATUS    (8'h02),
    .PORT_MASK      (8'h03)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .port_id      (port_id),
    .read_strobe  (read_strobe),
    .write_strobe (write_strobe),
    .out_port     (out_port),
    .in_data      (in_data),
    .in_sel       (in_sel),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack),
    .btn_level    (btn_level),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] exp_q[$];     // {interrupt, btn_level} per cycle
  logic [8:0] exp_rd_q[$];  // {in_sel, in_data} per read

  task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A button level changes once the synchronised pin (two cycles late) has
  // disagreed with it for DC consecutive cycles. Pending collects 0->1
  // level changes; a request is raised while any unmasked pending bit
  // exists, dropped on ack, and not raised again until none remain.
  logic [N_BTN-1:0] m_s1, m_s2, m_lvl, m_pend, m_mask;
  int               m_run[N_BTN];
  bit               m_irq, m_served;
  logic [N_BTN-1:0] t_rise, t_lvl, t_clr;
  bit               t_active;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_mask = '1;
      for (int i = 0; i < N_BTN; i++) m_run[i] = 0;
      m_irq = 0; m_served = 0;
    end else begin
      t_active = |(m_pend & m_mask);
      t_rise   = '0;
      t_lvl    = m_lvl;
      for (int i = 0; i < N_BTN; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DC) begin
            t_lvl[i]  = m_s2[i];
            t_rise[i] = m_s2[i];
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (!t_active) begin
        m_irq = 0; m_served = 0;
      end else if (m_served) begin
        m_irq = 0;
      end else if (m_irq && interrupt_ack) begin
        m_irq = 0; m_served = 1;
      end else begin
        m_irq = 1;
      end
      t_clr  = (write_strobe && port_id == 8'h02) ? out_port[N_BTN-1:0] : '0;
      m_pend = (m_pend & ~t_clr) | t_rise;
      if (write_strobe && port_id == 8'h03) m_mask = out_port[N_BTN-1:0];
      m_lvl = t_lvl;
      m_s2  = m_s1;
      m_s1  = btn_raw;
    end
    exp_q.push_back({m_irq, m_lvl});
  end

  function automatic logic [8:0] model_read(input logic [7:0] p);
    if (p == 8'h02) return {1'b1, 2'b00, m_pend, 2'b00, m_lvl};
    if (p == 8'h03) return {1'b1, 6'b000000, m_mask};
    return 9'h000;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [2:0] e;
    logic [8:0] r;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("btn_level", {7'b0, btn_level}, {7'b0, e[1:0]});
      chk("interrupt", {8'b0, interrupt}, {8'b0, e[2]});
    end
    if (read_strobe) begin
      if (exp_rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL read_queue: read seen with no expectation at %0t", $time);
      end else begin
        r = exp_rd_q.pop_front();
        chk("read_data", {in_sel, in_data}, r);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    write_strobe  = 1'b0;
    read_strobe   = 1'b0;
    interrupt_ack = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_write(input logic [7:0] p, input logic [7:0] d);
    port_id      = p;
    out_port     = d;
    write_strobe = 1'b1;
    tick();
  endtask

  task automatic do_read_expect(input string nm, input logic [7:0] p, input logic [8:0] exp);
    port_id     = p;
    read_strobe = 1'b1;
    exp_rd_q.push_back(model_read(p));
    #1;
    chk(nm, {in_sel, in_data}, exp);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; btn_raw = '0; port_id = 8'h00; read_strobe = 1'b0;
    write_strobe = 1'b0; out_port = 8'h00; interrupt_ack = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    settle();
    chk("reset_level", {7'b0, btn_level}, 9'h000);
    chk("reset_irq", {8'b0, interrupt}, 9'h000);
    chk("reset_state", {7'b0, dbg_state}, 9'h000);
    do_read_expect("reset_mask", 8'h03, 9'h103);
    do_read_expect("reset_status", 8'h02, 9'h100);

    // Bounce rejection: 3-cycle pulses never pass a 4-cycle filter.
    for (int k = 0; k < 5; k++) begin
      btn_raw = 2'b01; ticks(3);
      btn_raw = 2'b00; ticks(3);
    end
    ticks(8);
    settle();
    chk("bounce_level", {7'b0, btn_level}, 9'h000);
    chk("bounce_irq", {8'b0, interrupt}, 9'h000);
    do_read_expect("bounce_status", 8'h02, 9'h100);

    // Clean press: level after 6 edges, interrupt one edge later.
    btn_raw = 2'b01;
    ticks(5);
    settle();
    chk("press_level_early", {7'b0, btn_level}, 9'h000);
    tick();
    settle();
    chk("press_level", {7'b0, btn_level}, 9'h001);
    chk("press_irq_early", {8'b0, interrupt}, 9'h000);
    tick();
    settle();
    chk("press_irq", {8'b0, interrupt}, 9'h001);
    do_read_expect("press_status", 8'h02, 9'h111);

    // Handshake: ack drops the request, clearing pending returns to idle.
    interrupt_ack = 1'b1;
    tick();
    settle();
    chk("ack_irq", {8'b0, interrupt}, 9'h000);
    do_write(8'h02, 8'h01);
    tick();
    settle();
    chk("clear_state_idle", {7'b0, dbg_state}, 9'h000);
    chk("clear_irq", {8'b0, interrupt}, 9'h000);
    do_read_expect("clear_status", 8'h02, 9'h101);

    // Mask: masked event stays pending without a request until unmasked.
    do_write(8'h03, 8'h00);
    btn_raw = 2'b11;
    ticks(8);
    settle();
    chk("masked_irq", {8'b0, interrupt}, 9'h000);
    do_read_expect("masked_status", 8'h02, 9'h123);
    do_write(8'h03, 8'h02);
    settle();
    chk("unmask_irq_early", {8'b0, interrupt}, 9'h000);
    tick();
    settle();
    chk("unmask_irq", {8'b0, interrupt}, 9'h001);

    // Set/clear collision on pending[0]: the new event wins.
    btn_raw = 2'b10;
    ticks(8);
    btn_raw = 2'b11;
    ticks(5);
    do_write(8'h02, 8'h01);
    settle();
    do_read_expect("collision_status", 8'h02, 9'h133);

    // Reset while requesting.
    settle();
    chk("pre_reset_irq", {8'b0, interrupt}, 9'h001);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("midreq_reset_irq", {8'b0, interrupt}, 9'h000);
    chk("midreq_reset_level", {7'b0, btn_level}, 9'h000);
    do_read_expect("midreq_reset_status", 8'h02, 9'h100);
    do_read_expect("midreq_reset_mask", 8'h03, 9'h103);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N_BTN; i++)
        if ($urandom_range(0, 5) == 0) btn_raw[i] = ~btn_raw[i];
      interrupt_ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0:       port_id = 8'h02;
          1:       port_id = 8'h03;
          default: port_id = 8'h05;
        endcase
        out_port     = 8'($urandom_range(0, 255));
        write_strobe = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0:       port_id = 8'h02;
          1:       port_id = 8'h03;
          default: port_id = 8'h07;
        endcase
        read_strobe = 1'b1;
        exp_rd_q.push_back(model_read(port_id));
      end
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    ticks(2);
    settle();
    chk("read_queue_drained", 9'(exp_rd_q.size()), 9'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
